psum_ofifo: RTL and testbench
=============================

// Module: psum_ofifo
// PURPOSE
//  Output buffer downstream of the MAC column array. Each column pushes one bw_psum-bit psum on
//  its own write strobe (fifo_wr); columns arrive skewed by one cycle per column. The block
//  aligns them into full rows and hands one row (col psums) per read to the output/SFP stage.
//  Contains one small FIFO per column plus the row-level valid/full/overflow logic.
// PARAMETERS
//  col      8   number of MAC columns (lanes)
//  bw_psum  22  psum width per column (2*bw+6 with bw=8)
//  depth    16  entries per column FIFO; power of 2, >=2
// PORTS
//  clk      in   1              clock
//  reset    in   1              synchronous, active-high
//  wr       in   col            per-column push strobe; bit i = fifo_wr of column i
//  in       in   col*bw_psum    psum bus; column i at [(i+1)*bw_psum-1 : i*bw_psum]
//  rd       in   1              pop one full row
//  out      out  col*bw_psum    registered row output, same lane packing as in
//  o_valid  out  1              every column FIFO holds >=1 entry
//  o_full   out  1              any column FIFO holds depth entries
//  o_ready  out  1              ~o_full
//  o_ovf    out  1              sticky: a push was dropped on a full column
// BEHAVIOUR
//  - Reset: all pointers/counts 0, out=0, o_valid=0, o_full=0, o_ready=1, o_ovf=0.
//    Reset mid-operation discards all stored data. The first cycle after reset is idle.
//  - Per-column FIFO: wr_ptr, rd_ptr of log2(depth) bits (natural wrap). count of
//    log2(depth)+1 bits. Storage is a plain reg array, not reset.
//  - Push: wr[i]=1 and count_i<depth -> mem_i[wr_ptr_i] <= lane i, wr_ptr_i++ .
//    wr[i]=1 and count_i==depth -> data dropped, pointers unchanged, o_ovf <= 1 (sticky
//    until reset).
//  - Pop: rd=1 and o_valid=1 -> out <= heads of all columns; every rd_ptr_i++ on the same edge.
//    Data appears on out 1 cycle after the rd edge. out holds its value otherwise.
//    rd=1 with o_valid=0 is ignored: no pointer change, out unchanged, no error flag.
//  - Simultaneous push+pop on one column: both take effect; count_i unchanged.
//    On a full column a pop in the same cycle frees a slot, so the push is accepted (no ovf).
//    On an empty column the push is NOT visible to the same-cycle pop (o_valid already 0).
//  - o_valid, o_full, o_ready are combinational from the counts (registered state). They do
//    not depend on same-cycle rd/wr.
//  - Psums are passed through unmodified (signed, no saturation or extension). Lanes never mix.
//  - Columns are independent for writes. Rows form only when the slowest column has written;
//    skew up to depth-1 cycles is tolerated without loss.
// STRUCTURE
//  - Shared package/header: PSUM_BW, NUM_COL and FIFO_DEPTH defaults, plus a clog2 function
//    reused by other buffers.
//  - Sub-module: psum_col_fifo (params bw_psum, depth; ports clk, reset, wr, rd, in, out,
//    empty, full). Instantiate col copies via generate.
//  - Top level: AND-reduce ~empty for o_valid, OR-reduce full for o_full, the ovf flag, and
//    the out register.
// TESTING
//  1. Skewed row: col i pushes 100+i at cycle i (i=0..7). o_valid rises only after col7's
//     push. Then rd -> next cycle out lanes = 100..107, o_valid=0.
//  2. Fill: push 16 rows (lane i = 16*r+i), no rd -> o_full=1, o_ready=0. Then 16 rds -> rows
//     return in order r=0..15; o_valid drops after the last.
//  3. Overflow: with FIFOs full, push 999 on col3 only, no rd -> o_ovf=1 and stays 1.
//     Reading back shows col3 never returns 999.
//  4. Full + push + pop same cycle on all cols -> push accepted, o_ovf stays 0, o_full stays 1.
//     The later 16 reads end with the new row.
//  5. rd while empty -> out keeps its prior value, no pointer change. The next pushed row is
//     returned correctly.
//  6. Reset after 5 pushed rows -> o_valid=0, out=0, o_ovf=0. A fresh row 7..14 pushed then
//     read returns 7..14 exactly.

Source files
------------

// File: rtl/psum_ofifo_pkg.sv
// Shared sizing defaults for the psum output buffers and a constant-safe log2 helper.
package psum_ofifo_pkg;

  localparam int PSUM_BW    = 22;
  localparam int NUM_COL    = 8;
  localparam int FIFO_DEPTH = 16;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = 1; v < value; v = v * 2) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_col_fifo.sv
// Single-lane psum FIFO: unreset storage array, wrapping pointers and an occupancy count.
module psum_col_fifo
  import psum_ofifo_pkg::*;
#(
  parameter int bw_psum = PSUM_BW,
  parameter int depth   = FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               rd,
  input  logic [bw_psum-1:0] in,
  output logic [bw_psum-1:0] out,
  output logic               empty,
  output logic               full
);

  localparam int aw = clog2(depth);
  localparam logic [aw-1:0] ptr_one  = aw'(1);
  localparam logic [aw:0]   cnt_one  = (aw+1)'(1);
  localparam logic [aw:0]   cnt_full = (aw+1)'(depth);

  logic [bw_psum-1:0] mem [depth];
  logic [aw-1:0]      wr_ptr_reg;
  logic [aw-1:0]      rd_ptr_reg;
  logic [aw:0]        count_reg;
  logic               push;
  logic               pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == cnt_full);

  // A same-cycle pop frees the slot a push on a full lane needs.
  assign pop  = rd & ~empty;
  assign push = wr & (~full | pop);

  assign out = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + ptr_one;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + ptr_one;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + cnt_one;
        2'b01:   count_reg <= count_reg - cnt_one;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/psum_ofifo.sv
// Row-aligning output buffer: one FIFO per MAC column, rows popped only when every lane holds data.
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int col     = NUM_COL,
  parameter int bw_psum = PSUM_BW,
  parameter int depth   = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [col*bw_psum-1:0] in,
  input  logic                   rd,
  output logic [col*bw_psum-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_ovf
);

  logic [col-1:0]         empty_vec;
  logic [col-1:0]         full_vec;
  logic [col-1:0]         drop_vec;
  logic [col*bw_psum-1:0] head_bus;
  logic [col*bw_psum-1:0] out_reg;
  logic                   ovf_reg;
  logic                   pop;

  assign o_valid = &(~empty_vec);
  assign o_full  = |full_vec;
  assign o_ready = ~o_full;
  assign o_ovf   = ovf_reg;
  assign out     = out_reg;

  // Rows pop as a unit; a read with any lane empty is ignored.
  assign pop = rd & o_valid;

  genvar gi;
  generate
    for (gi = 0; gi < col; gi++) begin : g_col
      psum_col_fifo #(
        .bw_psum (bw_psum),
        .depth   (depth)
      ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (wr[gi]),
        .rd    (pop),
        .in    (in[gi*bw_psum +: bw_psum]),
        .out   (head_bus[gi*bw_psum +: bw_psum]),
        .empty (empty_vec[gi]),
        .full  (full_vec[gi])
      );
      assign drop_vec[gi] = wr[gi] & full_vec[gi] & ~pop;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg <= '0;
      ovf_reg <= 1'b0;
    end else begin
      if (pop) begin
        out_reg <= head_bus;
      end
      if (|drop_vec) begin
        ovf_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psum_ofifo.sv
// Randomized and directed bench for psum_ofifo against a queue-based row model.
module tb_psum_ofifo;
  import psum_ofifo_pkg::*;

  localparam int COL   = NUM_COL;
  localparam int BW    = PSUM_BW;
  localparam int DEPTH = FIFO_DEPTH;
  localparam int W     = COL * BW;

  logic           clk = 1'b0;
  logic           reset;
  logic [COL-1:0] wr;
  logic [W-1:0]   din;
  logic           rd;
  logic [W-1:0]   dout;
  logic           o_valid, o_full, o_ready, o_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one queue per lane, the last popped row and the sticky drop flag.
  logic [BW-1:0] q [COL][$];
  logic [W-1:0]  m_out;
  bit            m_ovf;

  always #5 clk = ~clk;

  psum_ofifo dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .in      (din),
    .rd      (rd),
    .out     (dout),
    .o_valid (o_valid),
    .o_full  (o_full),
    .o_ready (o_ready),
    .o_ovf   (o_ovf)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_row(input int base);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'(base + i);
    return r;
  endfunction

  task automatic cycle(input logic r, input logic [COL-1:0] w, input logic [W-1:0] d,
                       input logic rd_i);
    bit m_valid, m_full, pop;
    reset = r; wr = w; din = d; rd = rd_i;
    @(posedge clk);
    pop = 1'b0;
    if (r) begin
      for (int c = 0; c < COL; c++) q[c].delete();
      m_out = '0;
      m_ovf = 1'b0;
    end else begin
      m_valid = 1'b1;
      for (int c = 0; c < COL; c++) if (q[c].size() == 0) m_valid = 1'b0;
      pop = rd_i && m_valid;
      if (pop) begin
        for (int c = 0; c < COL; c++) m_out[c*BW +: BW] = q[c].pop_front();
      end
      for (int c = 0; c < COL; c++) begin
        if (w[c]) begin
          if (q[c].size() < DEPTH) q[c].push_back(d[c*BW +: BW]);
          else m_ovf = 1'b1;
        end
      end
    end
    m_valid = 1'b1;
    m_full  = 1'b0;
    for (int c = 0; c < COL; c++) begin
      if (q[c].size() == 0) m_valid = 1'b0;
      if (q[c].size() == DEPTH) m_full = 1'b1;
    end
    #1;
    if (pop) $display("rd row %h (ovf=%0b)", m_out, m_ovf);
    check("out", dout, m_out);
    check("o_valid", W'(o_valid), W'(m_valid));
    check("o_full", W'(o_full), W'(m_full));
    check("o_ready", W'(o_ready), W'(!m_full));
    check("o_ovf", W'(o_ovf), W'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] d;
    reset = 1'b1; wr = '0; din = '0; rd = 1'b0;
    cycle(1'b1, '0, '0, 1'b0);
    cycle(1'b1, '1, mk_row(55), 1'b1);
    idle(1);

    // 1: skewed row, one column per cycle
    for (int i = 0; i < COL; i++) begin
      d = '0;
      d[i*BW +: BW] = BW'(100 + i);
      cycle(1'b0, COL'(1) << i, d, 1'b0);
    end
    cycle(1'b0, '0, '0, 1'b1);
    check("skew_row", dout, mk_row(100));
    idle(1);

    // 2: fill to full, then drain in order
    for (int r = 0; r < DEPTH; r++) cycle(1'b0, '1, mk_row(16 * r), 1'b0);
    check("fill_full", W'(o_full), W'(1));
    // 3: drop on a full column, sticky flag
    d = '0;
    d[3*BW +: BW] = BW'(999);
    cycle(1'b0, COL'(8), d, 1'b0);
    idle(2);
    for (int r = 0; r < DEPTH; r++) cycle(1'b0, '0, '0, 1'b1);
    check("drain_last", dout, mk_row(16 * (DEPTH - 1)));
    check("ovf_sticky", W'(o_ovf), W'(1));

    // 4: full with simultaneous push and pop on every column
    cycle(1'b1, '0, '0, 1'b0);
    idle(1);
    for (int r = 0; r < DEPTH; r++) cycle(1'b0, '1, mk_row(32 * r), 1'b0);
    cycle(1'b0, '1, mk_row(700), 1'b1);
    check("pp_ovf", W'(o_ovf), W'(0));
    for (int r = 0; r < DEPTH; r++) cycle(1'b0, '0, '0, 1'b1);
    check("pp_last", dout, mk_row(700));

    // 5: reads while empty are ignored
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1);
    cycle(1'b0, '1, mk_row(300), 1'b1);
    cycle(1'b0, '0, '0, 1'b1);
    check("after_empty_rd", dout, mk_row(300));

    // 6: reset discards stored rows
    for (int r = 0; r < 5; r++) cycle(1'b0, '1, mk_row(40 + r), 1'b0);
    cycle(1'b1, '0, '0, 1'b0);
    idle(1);
    cycle(1'b0, '1, mk_row(7), 1'b0);
    cycle(1'b0, '0, '0, 1'b1);
    check("post_reset_row", dout, mk_row(7));

    // Random phase: skewed writes, bursts to full, random reads and rare resets
    for (int k = 0; k < 3000; k++) begin
      logic [COL-1:0] w;
      logic [W-1:0]   rd_data;
      for (int c = 0; c < COL; c++) begin
        w[c] = ($urandom_range(0, 99) < 60);
        rd_data[c*BW +: BW] = BW'($urandom);
      end
      if ((k / 200) % 2 == 1) w = ($urandom_range(0, 3) == 0) ? '1 : w;
      cycle(($urandom_range(0, 499) == 0), w, rd_data, ($urandom_range(0, 99) < ((k / 200) % 2 == 1 ? 25 : 55)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
